// File: rtl/cam_timing_monitor_pkg.sv
// Shared defaults for the OV camera timing monitor (VGA, RGB444 = 2 bytes/pixel)
// and the status-word bit positions used by the UART readout.
package cam_timing_monitor_pkg;

    localparam int CAM_FILT_LEN  = 8;
    localparam int CAM_EXP_LINES = 480;
    localparam int CAM_EXP_BYTES = 1280;
    localparam int CAM_CNT_W     = 16;
    localparam int CAM_PER_W     = 32;

    localparam int STS_LOCKED     = 0;
    localparam int STS_ERR_LINES  = 1;
    localparam int STS_ERR_BYTES  = 2;
    localparam int STS_MEAS_VALID = 3;

    typedef struct packed {
        logic lines;
        logic bytes;
    } cam_err_t;

endpackage

// File: rtl/cam_sync_filter.sv
// Glitch filter for one camera sync line: a rise is accepted once the input has been
// high for FILT_LEN-1 consecutive samples after a low sample.
module cam_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic cam_in_clk,
    input  logic rstn,
    input  logic i_in,
    output logic o_rise_pulse,
    output logic o_level
);

    localparam logic [FILT_LEN-1:0] RISE_PAT = {1'b0, {(FILT_LEN-1){1'b1}}};

    logic [FILT_LEN-1:0] r_sr;

    always_ff @(posedge cam_in_clk or negedge rstn) begin
        if (!rstn) r_sr <= '0;
        else       r_sr <= {r_sr[FILT_LEN-2:0], i_in};
    end

    assign o_rise_pulse = (r_sr == RISE_PAT);
    // Previous raw sample; the top uses it as the one-cycle-delayed level for edge detection.
    assign o_level      = r_sr[0];

endmodule

// File: rtl/cam_timing_monitor.sv
// Measures OV camera vsync/href timing: lines per frame, min/max bytes per line and
// frame period, with sticky mismatch flags against the expected VGA geometry.
module cam_timing_monitor
    import cam_timing_monitor_pkg::*;
#(
    parameter int FILT_LEN  = CAM_FILT_LEN,
    parameter int CNT_W     = CAM_CNT_W,
    parameter int PER_W     = CAM_PER_W,
    parameter int EXP_LINES = CAM_EXP_LINES,
    parameter int EXP_BYTES = CAM_EXP_BYTES
) (
    input  logic             cam_in_clk,
    input  logic             rstn,
    input  logic             i_cam_vsynk,
    input  logic             i_cam_href,
    input  logic             i_clr_err,
    output logic             o_frame_start,
    output logic             o_line_start,
    output logic             o_meas_valid,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_lines_last,
    output logic [CNT_W-1:0] o_bytes_min,
    output logic [CNT_W-1:0] o_bytes_max,
    output logic [PER_W-1:0] o_frame_period,
    output logic [15:0]      o_frame_cnt,
    output logic             o_err_lines,
    output logic             o_err_bytes
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
    localparam logic [CNT_W-1:0] EXP_L   = CNT_W'(EXP_LINES);
    localparam logic [CNT_W-1:0] EXP_B   = CNT_W'(EXP_BYTES);

    logic w_vs_in;
    logic w_frame_start;
    logic w_line_start;
    logic w_href_d;
    logic w_unused_vs_level;
    logic w_href_rise;
    logic w_href_fall;
    logic w_line_open;

    logic [CNT_W-1:0] r_byte_run;
    logic [CNT_W-1:0] r_line_acc;
    logic [CNT_W-1:0] r_min_acc;
    logic [CNT_W-1:0] r_max_acc;
    logic [PER_W-1:0] r_period_cnt;
    logic             r_line_q;
    cam_err_t         r_err;

    // vsync is only trusted while href is low, so a long href never looks like a frame edge.
    assign w_vs_in = i_cam_vsynk & ~i_cam_href;

    cam_sync_filter #(.FILT_LEN(FILT_LEN)) u_vs_filt (
        .cam_in_clk   (cam_in_clk),
        .rstn         (rstn),
        .i_in         (w_vs_in),
        .o_rise_pulse (w_frame_start),
        .o_level      (w_unused_vs_level)
    );

    cam_sync_filter #(.FILT_LEN(FILT_LEN)) u_hr_filt (
        .cam_in_clk   (cam_in_clk),
        .rstn         (rstn),
        .i_in         (i_cam_href),
        .o_rise_pulse (w_line_start),
        .o_level      (w_href_d)
    );

    assign w_href_rise   = i_cam_href & ~w_href_d;
    assign w_href_fall   = w_href_d & ~i_cam_href;
    // A line just qualified on its final high cycle still gets its length recorded.
    assign w_line_open   = r_line_q | w_line_start;
    assign o_frame_start = w_frame_start;
    assign o_line_start  = w_line_start;

    always_ff @(posedge cam_in_clk or negedge rstn) begin
        if (!rstn) begin
            r_byte_run     <= '0;
            r_line_acc     <= '0;
            r_min_acc      <= '1;
            r_max_acc      <= '0;
            r_period_cnt   <= '0;
            r_line_q       <= 1'b0;
            o_locked       <= 1'b0;
            o_meas_valid   <= 1'b0;
            o_lines_last   <= '0;
            o_bytes_min    <= '0;
            o_bytes_max    <= '0;
            o_frame_period <= '0;
            o_frame_cnt    <= '0;
        end else begin
            if (w_href_rise)
                r_byte_run <= CNT_ONE;
            else if (i_cam_href && r_byte_run != '1)
                r_byte_run <= r_byte_run + CNT_ONE;

            if (r_period_cnt != '1)
                r_period_cnt <= r_period_cnt + PER_ONE;

            o_meas_valid <= w_frame_start & o_locked;

            if (w_frame_start) begin
                if (o_locked) begin
                    o_frame_period <= r_period_cnt;
                    o_lines_last   <= r_line_acc;
                    o_bytes_min    <= (r_line_acc == '0) ? '0 : r_min_acc;
                    o_bytes_max    <= (r_line_acc == '0) ? '0 : r_max_acc;
                    o_frame_cnt    <= o_frame_cnt + 16'd1;
                end
                o_locked     <= 1'b1;
                r_period_cnt <= PER_ONE;
                r_line_acc   <= '0;
                r_min_acc    <= '1;
                r_max_acc    <= '0;
                r_line_q     <= 1'b0;
            end else begin
                if (w_line_start) begin
                    r_line_q <= 1'b1;
                    if (r_line_acc != '1)
                        r_line_acc <= r_line_acc + CNT_ONE;
                end
                if (w_href_fall && w_line_open) begin
                    if (r_byte_run < r_min_acc) r_min_acc <= r_byte_run;
                    if (r_byte_run > r_max_acc) r_max_acc <= r_byte_run;
                    r_line_q <= 1'b0;
                end
            end
        end
    end

    // Flags are judged on the freshly reported values; a new mismatch beats a same-cycle clear.
    always_ff @(posedge cam_in_clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= '0;
        end else begin
            r_err.lines <= (r_err.lines & ~i_clr_err)
                         | (o_meas_valid & (o_lines_last != EXP_L));
            r_err.bytes <= (r_err.bytes & ~i_clr_err)
                         | (o_meas_valid & ((o_bytes_min != EXP_B) | (o_bytes_max != EXP_B)));
        end
    end

    assign o_err_lines = r_err.lines;
    assign o_err_bytes = r_err.bytes;

endmodule

// File: tb/tb_cam_timing_monitor.sv
// Scoreboard bench for cam_timing_monitor: frames are described as lists of line lengths,
// the expected report is pushed at each closing vsync and popped by a meas_valid monitor.
module tb_cam_timing_monitor;

    localparam int FILT_LEN  = 8;
    localparam int CNT_W     = 16;
    localparam int PER_W     = 32;
    localparam int EXP_LINES = 6;
    localparam int EXP_BYTES = 24;

    logic             cam_in_clk = 1'b0;
    logic             rstn = 1'b0;
    logic             i_cam_vsynk = 1'b0;
    logic             i_cam_href = 1'b0;
    logic             i_clr_err = 1'b0;
    logic             o_frame_start, o_line_start, o_meas_valid, o_locked;
    logic [CNT_W-1:0] o_lines_last, o_bytes_min, o_bytes_max;
    logic [PER_W-1:0] o_frame_period;
    logic [15:0]      o_frame_cnt;
    logic             o_err_lines, o_err_bytes;

    cam_timing_monitor #(
        .FILT_LEN(FILT_LEN), .CNT_W(CNT_W), .PER_W(PER_W),
        .EXP_LINES(EXP_LINES), .EXP_BYTES(EXP_BYTES)
    ) dut (
        .cam_in_clk     (cam_in_clk),
        .rstn           (rstn),
        .i_cam_vsynk    (i_cam_vsynk),
        .i_cam_href     (i_cam_href),
        .i_clr_err      (i_clr_err),
        .o_frame_start  (o_frame_start),
        .o_line_start   (o_line_start),
        .o_meas_valid   (o_meas_valid),
        .o_locked       (o_locked),
        .o_lines_last   (o_lines_last),
        .o_bytes_min    (o_bytes_min),
        .o_bytes_max    (o_bytes_max),
        .o_frame_period (o_frame_period),
        .o_frame_cnt    (o_frame_cnt),
        .o_err_lines    (o_err_lines),
        .o_err_bytes    (o_err_bytes)
    );

    always #5 cam_in_clk = ~cam_in_clk;

    typedef struct {
        longint lines;
        longint bmin;
        longint bmax;
        longint period;
        longint fcnt;
        bit     el;
        bit     eb;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state
    bit  m_locked = 0;
    int  m_fcnt = 0;
    bit  m_el = 0, m_eb = 0;
    int  cur_lines = 0, cur_min = 0, cur_max = 0;
    int  cyc_since = 0;
    int  m_fs_total = 0, m_ls_total = 0, m_meas_total = 0;

    // monitor state
    int  n_fs = 0, n_ls = 0, n_meas = 0;
    bit  err_chk = 0;
    bit  err_exp_l = 0, err_exp_b = 0;

    function automatic void chk(input string nm, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endfunction

    always @(negedge cam_in_clk) begin
        if (rstn) begin
            if (o_frame_start) n_fs++;
            if (o_line_start)  n_ls++;
            if (err_chk) begin
                chk("err_lines", longint'(o_err_lines), longint'(err_exp_l));
                chk("err_bytes", longint'(o_err_bytes), longint'(err_exp_b));
                err_chk = 0;
            end
            if (o_meas_valid) begin
                n_meas++;
                if (q.size() == 0) begin
                    chk("meas_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("lines_last",   longint'(o_lines_last),   e.lines);
                    chk("bytes_min",    longint'(o_bytes_min),    e.bmin);
                    chk("bytes_max",    longint'(o_bytes_max),    e.bmax);
                    chk("frame_period", longint'(o_frame_period), e.period);
                    chk("frame_cnt",    longint'(o_frame_cnt),    e.fcnt);
                    err_exp_l = e.el;
                    err_exp_b = e.eb;
                    err_chk   = 1;
                end
            end
        end
    end

    task automatic cyc(input logic vs, input logic hr, input logic clr);
        i_cam_vsynk = vs;
        i_cam_href  = hr;
        i_clr_err   = clr;
        @(posedge cam_in_clk);
        #1;
        cyc_since++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Closes the previous frame (if locked) and opens a new one.
    task automatic vsync_pulse(input int len, input bit clr_meas);
        exp_t e;
        bit   nl, nb;
        if (m_locked) begin
            e.lines  = cur_lines;
            e.bmin   = (cur_lines == 0) ? 0 : cur_min;
            e.bmax   = (cur_lines == 0) ? 0 : cur_max;
            e.period = cyc_since;
            m_fcnt   = (m_fcnt + 1) % 65536;
            e.fcnt   = m_fcnt;
            nl = (e.lines != EXP_LINES);
            nb = (e.bmin != EXP_BYTES) || (e.bmax != EXP_BYTES);
            if (clr_meas) begin
                m_el = 0;
                m_eb = 0;
            end
            m_el = m_el | nl;
            m_eb = m_eb | nb;
            e.el = m_el;
            e.eb = m_eb;
            q.push_back(e);
            m_meas_total++;
        end
        m_locked  = 1;
        cur_lines = 0;
        cur_min   = 1 << 30;
        cur_max   = 0;
        cyc_since = 0;
        m_fs_total++;
        for (int i = 0; i < len; i++) begin
            cyc(1'b1, 1'b0, clr_meas && (i == FILT_LEN));
            if (i == FILT_LEN - 3) chk("frame_start_early", longint'(o_frame_start), 0);
            if (i == FILT_LEN - 2) chk("frame_start_lat",   longint'(o_frame_start), 1);
            if (i == FILT_LEN - 1) chk("frame_start_once",  longint'(o_frame_start), 0);
        end
    endtask

    task automatic line(input int len);
        for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, 1'b0);
        cur_lines++;
        m_ls_total++;
        if (len < cur_min) cur_min = len;
        if (len > cur_max) cur_max = len;
        idle($urandom_range(3, 15));
    endtask

    task automatic frame(input int nlines, input bit jitter, input int bad_idx, input int bad_len,
                         input bit glitch, input bit clr_meas, input bit clr_mid);
        vsync_pulse(FILT_LEN + 4 + $urandom_range(0, 12), clr_meas);
        idle($urandom_range(8, 20));
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = EXP_BYTES;
            if (l == bad_idx)
                len = bad_len;
            else if (jitter && $urandom_range(0, 3) == 0)
                len = EXP_BYTES - 4 + $urandom_range(0, 8);
            line(len);
            if (glitch && l == nlines / 2) begin
                for (int i = 0; i < FILT_LEN - 3; i++) cyc(1'b0, 1'b1, 1'b0);
                idle(6);
                for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
                idle(6);
            end
            if (clr_mid && l == 0) begin
                cyc(1'b0, 1'b0, 1'b1);
                m_el = 0;
                m_eb = 0;
                idle(2);
                chk("clr_err_lines", longint'(o_err_lines), 0);
                chk("clr_err_bytes", longint'(o_err_bytes), 0);
            end
        end
        idle($urandom_range(10, 30));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_frame_start"},  longint'(o_frame_start),  0);
        chk({tag, "_line_start"},   longint'(o_line_start),   0);
        chk({tag, "_meas_valid"},   longint'(o_meas_valid),   0);
        chk({tag, "_locked"},       longint'(o_locked),       0);
        chk({tag, "_lines_last"},   longint'(o_lines_last),   0);
        chk({tag, "_bytes_min"},    longint'(o_bytes_min),    0);
        chk({tag, "_bytes_max"},    longint'(o_bytes_max),    0);
        chk({tag, "_frame_period"}, longint'(o_frame_period), 0);
        chk({tag, "_frame_cnt"},    longint'(o_frame_cnt),    0);
        chk({tag, "_err_lines"},    longint'(o_err_lines),    0);
        chk({tag, "_err_bytes"},    longint'(o_err_bytes),    0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        idle(4);
        chk_all_zero("reset");
        rstn = 1'b1;
        idle(5);

        // nominal: first vsync only locks, then two clean reports
        frame(EXP_LINES, 0, -1, 0, 0, 0, 0);
        chk("locked_after_first", longint'(o_locked), 1);
        frame(EXP_LINES, 0, -1, 0, 0, 0, 0);
        frame(EXP_LINES, 0, -1, 0, 0, 0, 0);
        // sync glitches must be ignored
        frame(EXP_LINES, 0, -1, 0, 1, 0, 0);
        // short line, then clear, then clean frame
        frame(EXP_LINES, 0, $urandom_range(0, EXP_LINES - 1), EXP_BYTES - 2, 0, 0, 0);
        frame(EXP_LINES, 0, -1, 0, 0, 0, 1);
        frame(EXP_LINES, 0, -1, 0, 0, 0, 0);
        // wrong line count twice; clear coincides with the second bad report
        frame(EXP_LINES - 1, 0, -1, 0, 0, 0, 0);
        frame(EXP_LINES - 1, 0, -1, 0, 0, 0, 0);
        frame(EXP_LINES, 0, -1, 0, 0, 1, 1);
        // empty frames
        frame(0, 0, -1, 0, 0, 0, 0);
        frame(0, 0, -1, 0, 0, 0, 0);
        // randomized geometry
        for (int f = 0; f < 5; f++)
            frame(EXP_LINES - 1 + $urandom_range(0, 2), 1, -1, 0, $urandom_range(0, 1), 0, 0);

        // reset in the middle of a frame
        vsync_pulse(FILT_LEN + 6, 0);
        idle(10);
        line(EXP_BYTES);
        line(EXP_BYTES);
        cyc(1'b0, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        chk_all_zero("midreset");
        i_cam_href = 1'b0;
        idle(5);
        m_locked = 0;
        m_fcnt   = 0;
        m_el     = 0;
        m_eb     = 0;
        err_chk  = 0;
        q.delete();
        rstn = 1'b1;
        idle(5);
        frame(EXP_LINES, 1, -1, 0, 0, 0, 0);
        chk("relock_no_report", longint'(o_frame_cnt), 0);
        frame(EXP_LINES, 1, -1, 0, 0, 0, 0);
        vsync_pulse(FILT_LEN + 4, 0);
        idle(20);

        chk("queue_drained",     longint'(q.size()), 0);
        chk("frame_start_count", longint'(n_fs),     longint'(m_fs_total));
        chk("line_start_count",  longint'(n_ls),     longint'(m_ls_total));
        chk("meas_valid_count",  longint'(n_meas),   longint'(m_meas_total));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
